minterm_scanner: RTL

Sequential truth-table extractor: on `start` it sweeps an N-input vector through all 2^N combinations, drives it to a combinational function under test, samples that function's 1-bit output after a programmable settle time, and builds the function's minterm mask. It compares the captured mask against an expected mask and reports match, mismatch count and first failing minterm. It sits beside the sum-of-products evaluators as their self-checking driver and reader, replacing hand-written stimulus sweeps.

---
 rtl/minterm_scanner_pkg.sv | 20 ++
 rtl/settle_timer.sv | 26 ++
 rtl/minterm_scanner.sv | 111 +++++++++++
 3 files changed

// File: rtl/minterm_scanner_pkg.sv
// rtl/minterm_scanner_pkg.sv - shared state encoding and sizing helpers for the minterm scanner
package minterm_scanner_pkg;

  // Scan sequencer states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } scan_state_t;

  // Settle counter width; SETTLE is limited to 1..15.
  localparam int SETTLE_W = 4;

  // Number of input combinations for an n-input function.
  function automatic int scan_len(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - counts hold cycles for each applied vector
module settle_timer
  import minterm_scanner_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expired
);

  logic [SETTLE_W-1:0] count;

  // Free-running count while the vector is held; cleared between vectors.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == SETTLE_W'(SETTLE - 1));

endmodule

// File: rtl/minterm_scanner.sv
// rtl/minterm_scanner.sv - sweeps all input vectors, captures the minterm mask and compares it
module minterm_scanner
  import minterm_scanner_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int SETTLE   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [(1<<N_INPUTS)-1:0]    expected,
  output logic [N_INPUTS-1:0]         vec_out,
  input  logic                        f_in,
  output logic                        busy,
  output logic                        done,
  output logic [(1<<N_INPUTS)-1:0]    table_out,
  output logic                        match,
  output logic [N_INPUTS:0]           mismatch_cnt,
  output logic                        any_bad,
  output logic [N_INPUTS-1:0]         first_bad
);

  localparam int LEN = scan_len(N_INPUTS);

  scan_state_t        state;
  logic [LEN-1:0]     expected_q;
  logic               timer_clear;
  logic               timer_expired;
  logic               bit_bad;
  logic [N_INPUTS:0]  cnt_next;

  // Timer only runs while a vector is being held; it restarts for every vector.
  assign timer_clear = (state != APPLY) || timer_expired;

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .expired (timer_expired)
  );

  assign bit_bad  = (f_in != expected_q[vec_out]);
  assign cnt_next = mismatch_cnt + {{N_INPUTS{1'b0}}, bit_bad};

  // Scan sequencer with capture, compare and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      expected_q   <= '0;
      vec_out      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      table_out    <= '0;
      match        <= 1'b0;
      mismatch_cnt <= '0;
      any_bad      <= 1'b0;
      first_bad    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            expected_q   <= expected;
            table_out    <= '0;
            mismatch_cnt <= '0;
            any_bad      <= 1'b0;
            first_bad    <= '0;
            match        <= 1'b0;
            vec_out      <= '0;
            busy         <= 1'b1;
            state        <= APPLY;
          end
        end
        APPLY: begin
          if (timer_expired) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          table_out[vec_out] <= f_in;
          if (bit_bad) begin
            mismatch_cnt <= cnt_next;
            if (!any_bad) begin
              first_bad <= vec_out;
              any_bad   <= 1'b1;
            end
          end
          if (vec_out == '1) begin
            // Result is final here, so match is already valid while done is high.
            match <= (cnt_next == '0);
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            vec_out <= vec_out + 1'b1;
            state   <= APPLY;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          match <= (mismatch_cnt == '0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
